sine_period_meter: RTL and testbench

Measures period and amplitude of an incoming 8-bit offset-binary sine stream (midpoint 127, full scale 0..254), the inverse of the sine lookup table used for waveform generation. It sits on the sample path after the generator or ADC capture. It detects rising midpoint crossings with hysteresis, counts accepted samples between successive crossings, and tracks the running min/max over each period. Results are published as a registered measurement with a one-cycle valid strobe.

---
 rtl/sine_period_meter.sv | 93 +++++++++
 tb/tb_sine_period_meter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sine_period_meter.sv
// rtl/sine_period_meter.sv - period and amplitude meter for an offset-binary sine sample stream
// Rising midpoint crossings with hysteresis delimit periods; min/max tracked per period.
module sine_period_meter #(
    parameter int MID  = 127,
    parameter int HYST = 4,
    parameter int PW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_sample,
    output logic          meas_valid,
    output logic [PW-1:0] period,
    output logic [7:0]    vmax,
    output logic [7:0]    vmin,
    output logic [7:0]    p2p,
    output logic          locked,
    output logic          timeout
);

    localparam logic [7:0]    LO_TH   = 8'(MID - HYST);
    localparam logic [7:0]    HI_TH   = 8'(MID + HYST);
    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic {SEEK_LOW, SEEK_HIGH} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] cnt;
    logic [7:0]    run_max, run_min;
    logic          low_ev, high_ev, crossing, advance, saturate;

    always_comb begin
        low_ev    = in_valid && (in_sample < LO_TH);
        high_ev   = in_valid && (in_sample > HI_TH);
        crossing  = (state == SEEK_HIGH) && high_ev;
        advance   = in_valid && !crossing && locked;
        saturate  = advance && (cnt == CNT_MAX);
        state_nxt = state;
        case (state)
            SEEK_LOW:  if (low_ev)  state_nxt = SEEK_HIGH;
            SEEK_HIGH: if (high_ev) state_nxt = SEEK_LOW;
            default:   state_nxt = SEEK_LOW;
        endcase
        // A saturated count means the input lost its periodicity: re-arm from scratch.
        if (saturate) state_nxt = SEEK_LOW;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEEK_LOW;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked     <= 1'b0;
            cnt        <= '0;
            run_max    <= 8'd0;
            run_min    <= 8'd255;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            period     <= '0;
            vmax       <= 8'd0;
            vmin       <= 8'd0;
            p2p        <= 8'd0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (crossing) begin
                if (locked) begin
                    period     <= cnt;
                    vmax       <= run_max;
                    vmin       <= run_min;
                    p2p        <= run_max - run_min;
                    meas_valid <= 1'b1;
                end
                // The crossing sample opens the new period.
                locked  <= 1'b1;
                cnt     <= CNT_ONE;
                run_max <= in_sample;
                run_min <= in_sample;
            end else if (saturate) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
            end else if (advance) begin
                cnt <= cnt + CNT_ONE;
                if (in_sample > run_max) run_max <= in_sample;
                if (in_sample < run_min) run_min <= in_sample;
            end
        end
    end

endmodule

// File: tb/tb_sine_period_meter.sv
// tb/tb_sine_period_meter.sv - directed table and sweep bench for sine_period_meter
module tb_sine_period_meter;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_sample = 8'd0;
    logic          meas_valid;
    logic [PW-1:0] period;
    logic [7:0]    vmax, vmin, p2p;
    logic          locked, timeout;

    sine_period_meter #(.MID(127), .HYST(4), .PW(PW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
        .meas_valid(meas_valid), .period(period), .vmax(vmax), .vmin(vmin),
        .p2p(p2p), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] s;
        logic       mv;
        logic       lk;
        logic [7:0] per;
        logic [7:0] mx;
        logic [7:0] mn;
        logic [7:0] pp;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] lut  [128];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nsamp = 0;
    int tout_cnt = 0;
    int m_ord [$];
    int m_cyc [$];
    int m_per [$];
    int m_mx  [$];
    int m_mn  [$];
    int m_pp  [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic feed(input logic v, input logic [7:0] s);
        int ord;
        ord = nsamp;
        in_valid  = v;
        in_sample = s;
        @(posedge clk);
        #1;
        cyc++;
        if (v) nsamp++;
        if (meas_valid && timeout) chk("strobe_overlap", 1, 0);
        if (timeout) tout_cnt++;
        if (meas_valid) begin
            m_ord.push_back(ord);
            m_cyc.push_back(cyc);
            m_per.push_back(int'(period));
            m_mx.push_back(int'(vmax));
            m_mn.push_back(int'(vmin));
            m_pp.push_back(int'(p2p));
        end
    endtask

    task automatic clear_log();
        nsamp = 0;
        tout_cnt = 0;
        m_ord.delete(); m_cyc.delete(); m_per.delete();
        m_mx.delete();  m_mn.delete();  m_pp.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    task automatic sweep(input int stride, input int gap, input int laps);
        for (int l = 0; l < laps; l++)
            for (int i = 0; i < 128; i += stride) begin
                if (gap != 0) feed(1'b0, 8'd0);
                feed(1'b1, lut[i]);
            end
    endtask

    task automatic check_sweep(input string name, input int n_exp, input int first_ord,
                               input int step_ord, input int per_exp, input int step_cyc);
        chk({name, "_count"}, m_ord.size(), n_exp);
        for (int i = 0; i < m_ord.size() && i < n_exp; i++) begin
            chk({name, "_ord"},    m_ord[i], first_ord + i * step_ord);
            chk({name, "_period"}, m_per[i], per_exp);
            chk({name, "_vmax"},   m_mx[i], 254);
            chk({name, "_vmin"},   m_mn[i], 0);
            chk({name, "_p2p"},    m_pp[i], 254);
            if (i > 0 && step_cyc != 0) chk({name, "_spacing"}, m_cyc[i] - m_cyc[i-1], step_cyc);
        end
        chk({name, "_timeouts"}, tout_cnt, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_mv"},     int'(meas_valid), 0);
        chk({name, "_to"},     int'(timeout), 0);
        chk({name, "_locked"}, int'(locked), 0);
        chk({name, "_period"}, int'(period), 0);
        chk({name, "_vmax"},   int'(vmax), 0);
        chk({name, "_vmin"},   int'(vmin), 0);
        chk({name, "_p2p"},    int'(p2p), 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++)
            lut[i] = 8'($rtoi(127.0 + 127.0 * $sin(2.0 * 3.14159265358979 * i / 128.0) + 0.5));

        //          v  sample  mv lk per  max  min  p2p
        vecs[0]  = '{1'b1, 8'd100, 1'b0, 1'b0, 8'd0, 8'd0,   8'd0,   8'd0};
        vecs[1]  = '{1'b1, 8'd140, 1'b0, 1'b1, 8'd0, 8'd0,   8'd0,   8'd0};
        vecs[2]  = '{1'b1, 8'd130, 1'b0, 1'b1, 8'd0, 8'd0,   8'd0,   8'd0};
        vecs[3]  = '{1'b0, 8'd0,   1'b0, 1'b1, 8'd0, 8'd0,   8'd0,   8'd0};
        vecs[4]  = '{1'b1, 8'd50,  1'b0, 1'b1, 8'd0, 8'd0,   8'd0,   8'd0};
        vecs[5]  = '{1'b1, 8'd132, 1'b1, 1'b1, 8'd3, 8'd140, 8'd50,  8'd90};
        vecs[6]  = '{1'b1, 8'd131, 1'b0, 1'b1, 8'd3, 8'd140, 8'd50,  8'd90};
        vecs[7]  = '{1'b1, 8'd123, 1'b0, 1'b1, 8'd3, 8'd140, 8'd50,  8'd90};
        vecs[8]  = '{1'b1, 8'd122, 1'b0, 1'b1, 8'd3, 8'd140, 8'd50,  8'd90};
        vecs[9]  = '{1'b0, 8'd255, 1'b0, 1'b1, 8'd3, 8'd140, 8'd50,  8'd90};
        vecs[10] = '{1'b1, 8'd254, 1'b1, 1'b1, 8'd4, 8'd132, 8'd122, 8'd10};
        vecs[11] = '{1'b1, 8'd254, 1'b0, 1'b1, 8'd4, 8'd132, 8'd122, 8'd10};

        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();

        for (int k = 0; k < 12; k++) begin
            feed(vecs[k].v, vecs[k].s);
            chk($sformatf("vec%0d_mv", k),     int'(meas_valid), int'(vecs[k].mv));
            chk($sformatf("vec%0d_locked", k), int'(locked),     int'(vecs[k].lk));
            chk($sformatf("vec%0d_period", k), int'(period),     int'(vecs[k].per));
            chk($sformatf("vec%0d_vmax", k),   int'(vmax),       int'(vecs[k].mx));
            chk($sformatf("vec%0d_vmin", k),   int'(vmin),       int'(vecs[k].mn));
            chk($sformatf("vec%0d_p2p", k),    int'(p2p),        int'(vecs[k].pp));
            chk($sformatf("vec%0d_to", k),     int'(timeout),    0);
        end

        do_reset();
        for (int k = 0; k < 40; k++) feed(1'b1, (k % 2 == 0) ? 8'd124 : 8'd130);
        chk("noise_meas", m_ord.size(), 0);
        chk("noise_locked", int'(locked), 0);
        feed(1'b1, 8'd140);
        chk("noise_still_seek_low", int'(locked), 0);

        do_reset();
        sweep(1, 0, 1);
        chk("lock_lap1", int'(locked), 0);
        feed(1'b1, lut[0]);
        chk("lock_idx0", int'(locked), 0);
        feed(1'b1, lut[1]);
        chk("lock_idx1", int'(locked), 1);
        chk("lock_no_meas", m_ord.size(), 0);

        do_reset();
        sweep(1, 0, 5);
        check_sweep("stride1", 3, 257, 128, 128, 128);

        do_reset();
        sweep(2, 0, 4);
        check_sweep("stride2", 2, 129, 64, 64, 64);

        do_reset();
        sweep(1, 1, 4);
        check_sweep("gaps", 2, 257, 128, 128, 256);

        do_reset();
        sweep(1, 0, 1);
        feed(1'b1, lut[0]);
        feed(1'b1, lut[1]);
        chk("to_locked", int'(locked), 1);
        for (int k = 0; k < 254; k++) feed(1'b1, 8'd200);
        chk("to_early", tout_cnt, 0);
        chk("to_locked_at_255", int'(locked), 1);
        feed(1'b1, 8'd200);
        chk("to_pulse", int'(timeout), 1);
        chk("to_unlocked", int'(locked), 0);
        chk("to_no_meas", int'(meas_valid), 0);
        feed(1'b1, 8'd200);
        chk("to_width", int'(timeout), 0);
        chk("to_stays_unlocked", int'(locked), 0);
        clear_log();
        sweep(1, 0, 3);
        check_sweep("after_to", 1, 257, 128, 128, 0);

        do_reset();
        sweep(1, 0, 2);
        for (int i = 0; i <= 60; i++) feed(1'b1, lut[i]);
        chk("pre_rst_meas", m_ord.size(), 1);
        chk("pre_rst_locked", int'(locked), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        sweep(1, 0, 3);
        check_sweep("post_rst", 1, 257, 128, 128, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
